// File: rtl/fetch_pkg.sv
// Shared widths and the fetch bundle payload used by the fetch front end.
package fetch_pkg;

  localparam int unsigned FETCH_BYTES = 8;
  localparam int unsigned INST_WIDTH  = 32;
  localparam int unsigned PC_WIDTH    = 32;

  typedef struct packed {
    logic [PC_WIDTH-1:0]   pc;
    logic [INST_WIDTH-1:0] inst0;
    logic [INST_WIDTH-1:0] inst1;
  } fetch_bundle_t;

endpackage

// File: rtl/fetch_queue.sv
// Two-entry synchronous FIFO of fetch bundles with flush; head is the oldest entry.
module fetch_queue
  import fetch_pkg::*;
(
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          enq_i,
  input  logic          deq_i,
  input  logic          flush_i,
  input  fetch_bundle_t enq_data_i,
  output logic [1:0]    count_o,
  output fetch_bundle_t head_o
);

  fetch_bundle_t entry_q [2];
  fetch_bundle_t entry_d [2];
  logic          rd_ptr_q, rd_ptr_d;
  logic [1:0]    count_q, count_d;
  logic          wr_ptr;

  always_comb begin
    entry_d  = entry_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    // Tail slot is rd_ptr + count modulo 2; when full with a dequeue it reuses the head slot.
    wr_ptr   = rd_ptr_q ^ count_q[0];
    if (flush_i) begin
      rd_ptr_d = 1'b0;
      count_d  = 2'd0;
    end else begin
      if (enq_i) begin
        entry_d[wr_ptr] = enq_data_i;
      end
      if (deq_i) begin
        rd_ptr_d = ~rd_ptr_q;
      end
      count_d = count_q + 2'(enq_i) - 2'(deq_i);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      entry_q  <= '{default: '0};
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      entry_q  <= entry_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign count_o = count_q;
  assign head_o  = entry_q[rd_ptr_q];

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch front end: PC, one 8-byte BRAM read per cycle, credit-limited
// issue into a 2-entry bundle queue, and flush-on-redirect.
module fetch_unit #(
  parameter int unsigned           ADDR_WIDTH  = 32,
  parameter int unsigned           INST_WIDTH  = 32,
  parameter int unsigned           FETCH_WIDTH = 64,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC    = '0
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic                   redirect_valid,
  input  logic [ADDR_WIDTH-1:0]  redirect_pc,
  output logic [ADDR_WIDTH-1:0]  mem_req_addr,
  output logic                   mem_req_valid,
  input  logic [FETCH_WIDTH-1:0] mem_resp_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [ADDR_WIDTH-1:0]  out_pc,
  output logic [INST_WIDTH-1:0]  out_inst0,
  output logic [INST_WIDTH-1:0]  out_inst1
);

  import fetch_pkg::*;

  localparam int unsigned OCC_WIDTH = 3;

  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic [ADDR_WIDTH-1:0] inflight_pc_q, inflight_pc_d;
  logic                  inflight_q, inflight_d;
  logic [1:0]            count;
  logic [OCC_WIDTH-1:0]  occupancy;
  logic                  credit_ok;
  logic                  deq;
  logic                  enq;
  fetch_bundle_t         head;
  fetch_bundle_t         enq_data;

  // Handshake, credit and request address.
  always_comb begin
    out_valid     = (count != 2'd0) & ~redirect_valid & ~RST;
    deq           = out_valid & out_ready;
    occupancy     = OCC_WIDTH'(count) + OCC_WIDTH'(inflight_q);
    // A slot freed by this cycle's dequeue counts as credit for a new request.
    credit_ok     = occupancy < (OCC_WIDTH'(2) + OCC_WIDTH'(deq));
    mem_req_valid = ~RST & (redirect_valid | credit_ok);
    mem_req_addr  = redirect_valid ? {redirect_pc[ADDR_WIDTH-1:2], 2'b00} : pc_q;
    enq           = inflight_q & ~redirect_valid & ~RST;
  end

  always_comb begin
    pc_d          = pc_q;
    inflight_d    = 1'b0;
    inflight_pc_d = inflight_pc_q;
    if (mem_req_valid) begin
      pc_d          = mem_req_addr + ADDR_WIDTH'(FETCH_BYTES);
      inflight_d    = 1'b1;
      inflight_pc_d = mem_req_addr;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      pc_q          <= RESET_PC;
      inflight_q    <= 1'b0;
      inflight_pc_q <= '0;
    end else begin
      pc_q          <= pc_d;
      inflight_q    <= inflight_d;
      inflight_pc_q <= inflight_pc_d;
    end
  end

  always_comb begin
    enq_data.pc    = inflight_pc_q;
    enq_data.inst0 = mem_resp_data[INST_WIDTH-1:0];
    enq_data.inst1 = mem_resp_data[FETCH_WIDTH-1:INST_WIDTH];
  end

  fetch_queue u_queue (
    .clk_i      (CLK),
    .rst_i      (RST),
    .enq_i      (enq),
    .deq_i      (deq),
    .flush_i    (redirect_valid),
    .enq_data_i (enq_data),
    .count_o    (count),
    .head_o     (head)
  );

  // Head fields read as zero while reset is asserted.
  always_comb begin
    out_pc    = RST ? '0 : head.pc;
    out_inst0 = RST ? '0 : head.inst0;
    out_inst1 = RST ? '0 : head.inst1;
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: BRAM model returns word index (addr>>2) per word,
// and a scoreboard tracks the next bundle address decode must see.
module tb_fetch_unit;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic [31:0] mem_req_addr;
  logic        mem_req_valid;
  logic [63:0] mem_resp_data = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_pc;
  logic [31:0] out_inst0;
  logic [31:0] out_inst1;

  int          vectors = 0;
  int          errors  = 0;
  logic [31:0] exp_pc  = '0;

  always #5 CLK = ~CLK;

  fetch_unit #(
    .ADDR_WIDTH (32),
    .INST_WIDTH (32),
    .FETCH_WIDTH(64),
    .RESET_PC   (32'h0)
  ) dut (
    .CLK           (CLK),
    .RST           (RST),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .mem_req_addr  (mem_req_addr),
    .mem_req_valid (mem_req_valid),
    .mem_resp_data (mem_resp_data),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_pc        (out_pc),
    .out_inst0     (out_inst0),
    .out_inst1     (out_inst1)
  );

  function automatic logic [31:0] word_at(input logic [31:0] a);
    return {2'b00, a[31:2]};
  endfunction

  function automatic logic [95:0] exp_bundle(input logic [31:0] pc);
    return {pc, word_at(pc), word_at(pc + 32'd4)};
  endfunction

  // BRAM: one-cycle read latency, zero when not enabled.
  always @(posedge CLK) begin
    mem_resp_data <= mem_req_valid ? {word_at(mem_req_addr + 32'd4), word_at(mem_req_addr)} : 64'h0;
  end

  task automatic set_in(input logic rst, input logic rdy, input logic redir, input logic [31:0] rpc);
    RST = rst;
    out_ready = rdy;
    redirect_valid = redir;
    redirect_pc = rpc;
    #2;
  endtask

  // Advance one clock, updating the expected next bundle address from the cycle's events.
  task automatic adv();
    if (RST) exp_pc = 32'h0;
    else if (redirect_valid) exp_pc = {redirect_pc[31:2], 2'b00};
    else if (out_valid && out_ready) exp_pc = exp_pc + 32'd8;
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    set_in(1'b1, 1'b1, 1'b0, 32'h0);
    adv();
    set_in(1'b1, 1'b1, 1'b0, 32'h0);
    vectors++;
    if ({out_valid, mem_req_valid} !== 2'b00) begin
      errors++;
      $display("FAIL reset_valids: got out_valid=%b mem_req_valid=%b expected 0 0", out_valid, mem_req_valid);
    end
    vectors++;
    if ({out_pc, out_inst0, out_inst1} !== 96'h0) begin
      errors++;
      $display("FAIL reset_head: got %h expected 0", {out_pc, out_inst0, out_inst1});
    end
    adv();
  endtask

  task automatic test_stream();
    set_in(1'b0, 1'b1, 1'b0, 32'h0);
    vectors++;
    if ({mem_req_valid, mem_req_addr, out_valid} !== {1'b1, 32'h0, 1'b0}) begin
      errors++;
      $display("FAIL stream_cycle0: got req=%b addr=%h out_valid=%b expected 1 00000000 0", mem_req_valid, mem_req_addr, out_valid);
    end
    adv();
    set_in(1'b0, 1'b1, 1'b0, 32'h0);
    vectors++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL stream_cycle1: got out_valid=%b expected 0", out_valid);
    end
    adv();
    for (int i = 0; i < 10; i++) begin
      set_in(1'b0, 1'b1, 1'b0, 32'h0);
      vectors++;
      if (out_valid !== 1'b1) begin
        errors++;
        $display("FAIL stream_valid[%0d]: got %b expected 1", i, out_valid);
      end else if ({out_pc, out_inst0, out_inst1} !== exp_bundle(exp_pc)) begin
        errors++;
        $display("FAIL stream_bundle[%0d]: got %h expected %h", i, {out_pc, out_inst0, out_inst1}, exp_bundle(exp_pc));
      end
      adv();
    end
  endtask

  task automatic test_stall();
    for (int i = 0; i < 5; i++) begin
      set_in(1'b0, 1'b0, 1'b0, 32'h0);
      vectors++;
      if ({mem_req_valid, out_valid, out_pc} !== {1'b0, 1'b1, exp_pc}) begin
        errors++;
        $display("FAIL stall[%0d]: got req=%b valid=%b pc=%h expected 0 1 %h", i, mem_req_valid, out_valid, out_pc, exp_pc);
      end
      adv();
    end
    for (int i = 0; i < 8; i++) begin
      set_in(1'b0, 1'b1, 1'b0, 32'h0);
      if (i == 0) begin
        vectors++;
        if (mem_req_valid !== 1'b1) begin
          errors++;
          $display("FAIL stall_resume_issue: got %b expected 1", mem_req_valid);
        end
      end
      vectors++;
      if (out_valid !== 1'b1) begin
        errors++;
        $display("FAIL stall_release_valid[%0d]: got %b expected 1", i, out_valid);
      end else if ({out_pc, out_inst0, out_inst1} !== exp_bundle(exp_pc)) begin
        errors++;
        $display("FAIL stall_release_bundle[%0d]: got %h expected %h", i, {out_pc, out_inst0, out_inst1}, exp_bundle(exp_pc));
      end
      adv();
    end
  endtask

  // Redirect at cycle t; out_valid low at t and t+1, target bundles from t+2.
  task automatic test_redirect(input logic [31:0] target, input int fill, input int nbundles);
    for (int i = 0; i < fill; i++) begin
      set_in(1'b0, 1'b0, 1'b0, 32'h0);
      adv();
    end
    set_in(1'b0, (fill == 0), 1'b1, target);
    vectors++;
    if ({mem_req_valid, mem_req_addr, out_valid} !== {1'b1, target[31:2], 2'b00, 1'b0}) begin
      errors++;
      $display("FAIL redirect_issue(%h): got req=%b addr=%h valid=%b expected 1 %h 0", target, mem_req_valid, mem_req_addr, out_valid, {target[31:2], 2'b00});
    end
    adv();
    set_in(1'b0, 1'b1, 1'b0, 32'h0);
    vectors++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL redirect_t1(%h): got out_valid=%b expected 0", target, out_valid);
    end
    adv();
    for (int i = 0; i < nbundles; i++) begin
      set_in(1'b0, 1'b1, 1'b0, 32'h0);
      vectors++;
      if (out_valid !== 1'b1) begin
        errors++;
        $display("FAIL redirect_valid(%h)[%0d]: got %b expected 1", target, i, out_valid);
      end else if ({out_pc, out_inst0, out_inst1} !== exp_bundle(exp_pc)) begin
        errors++;
        $display("FAIL redirect_bundle(%h)[%0d]: got %h expected %h", target, i, {out_pc, out_inst0, out_inst1}, exp_bundle(exp_pc));
      end
      adv();
    end
  endtask

  task automatic test_reset_midstream();
    for (int i = 0; i < 3; i++) begin
      set_in(1'b0, 1'b1, 1'b0, 32'h0);
      adv();
    end
    set_in(1'b1, 1'b1, 1'b0, 32'h0);
    vectors++;
    if ({out_valid, mem_req_valid, out_pc} !== 34'h0) begin
      errors++;
      $display("FAIL midreset_during: got valid=%b req=%b pc=%h expected 0 0 0", out_valid, mem_req_valid, out_pc);
    end
    adv();
    set_in(1'b0, 1'b1, 1'b0, 32'h0);
    vectors++;
    if ({mem_req_valid, mem_req_addr, out_valid} !== {1'b1, 32'h0, 1'b0}) begin
      errors++;
      $display("FAIL midreset_cycle0: got req=%b addr=%h valid=%b expected 1 00000000 0", mem_req_valid, mem_req_addr, out_valid);
    end
    adv();
    set_in(1'b0, 1'b1, 1'b0, 32'h0);
    vectors++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL midreset_stale: got out_valid=%b expected 0", out_valid);
    end
    adv();
    for (int i = 0; i < 3; i++) begin
      set_in(1'b0, 1'b1, 1'b0, 32'h0);
      vectors++;
      if ({out_valid, out_pc, out_inst0, out_inst1} !== {1'b1, exp_bundle(exp_pc)}) begin
        errors++;
        $display("FAIL midreset_bundle[%0d]: got valid=%b %h expected 1 %h", i, out_valid, {out_pc, out_inst0, out_inst1}, exp_bundle(exp_pc));
      end
      adv();
    end
  endtask

  task automatic test_random();
    logic        rdy, redir;
    logic [31:0] rpc;
    int          wait_cycles;
    for (int i = 0; i < 400; i++) begin
      rdy   = ($urandom_range(0, 3) != 0);
      redir = ($urandom_range(0, 19) == 0);
      rpc   = $urandom;
      set_in(1'b0, rdy, redir, rpc);
      if (redir) begin
        vectors++;
        if ({mem_req_valid, mem_req_addr, out_valid} !== {1'b1, rpc[31:2], 2'b00, 1'b0}) begin
          errors++;
          $display("FAIL random_redirect[%0d]: got req=%b addr=%h valid=%b expected 1 %h 0", i, mem_req_valid, mem_req_addr, out_valid, {rpc[31:2], 2'b00});
        end
      end else if (out_valid && out_ready) begin
        vectors++;
        if ({out_pc, out_inst0, out_inst1} !== exp_bundle(exp_pc)) begin
          errors++;
          $display("FAIL random_bundle[%0d]: got %h expected %h", i, {out_pc, out_inst0, out_inst1}, exp_bundle(exp_pc));
        end
      end
      adv();
    end
    // Liveness: with decode ready, a bundle must appear within a small bound.
    wait_cycles = 0;
    set_in(1'b0, 1'b1, 1'b0, 32'h0);
    while (!out_valid && wait_cycles < 4) begin
      adv();
      set_in(1'b0, 1'b1, 1'b0, 32'h0);
      wait_cycles++;
    end
    vectors++;
    if (out_valid !== 1'b1) begin
      errors++;
      $display("FAIL random_drain: got out_valid=%b after %0d cycles expected 1", out_valid, wait_cycles);
    end else if ({out_pc, out_inst0, out_inst1} !== exp_bundle(exp_pc)) begin
      errors++;
      $display("FAIL random_drain_bundle: got %h expected %h", {out_pc, out_inst0, out_inst1}, exp_bundle(exp_pc));
    end
    adv();
  endtask

  initial begin
    test_reset();
    test_stream();
    test_stall();
    test_redirect(32'h0000_0106, 0, 4);
    test_redirect(32'h0000_2000, 4, 4);
    test_redirect(32'hFFFF_FFF8, 0, 3);
    test_reset_midstream();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch front end placed directly upstream of the dual-issue instruction BRAM. Holds the PC, issues one 8-byte (two-instruction) read per cycle to the BRAM's `req_addr`/`req_valid` port, captures the 64-bit response one cycle later into a 2-entry fetch queue, and presents {pc, inst0, inst1} bundles to decode through a valid/ready handshake. Handles branch redirects by flushing all queued and in-flight fetches.

## Interface
- `ADDR_WIDTH`, 32: PC and memory address width.
- `INST_WIDTH`, 32: instruction width.
- `FETCH_WIDTH`, 64: memory response width, equal to 2*INST_WIDTH.
- `RESET_PC`, 0: PC loaded on reset.

- `CLK` in 1: clock; all state updates on the rising edge.
- `RST` in 1: reset, synchronous, active-high.
- `redirect_valid` in 1: load a new PC and flush.
- `redirect_pc` in ADDR_WIDTH: redirect target; bits [1:0] are ignored and treated as 0.
- `mem_req_addr` out ADDR_WIDTH: byte address to the BRAM.
- `mem_req_valid` out 1: BRAM read enable.
- `mem_resp_data` in FETCH_WIDTH: BRAM data, valid the cycle after a request. [31:0] is the instruction at addr, [63:32] is the instruction at addr+4.
- `out_valid` out 1: bundle available to decode.
- `out_ready` in 1: decode accepts the bundle.
- `out_pc` out ADDR_WIDTH: address of `out_inst0`. `out_inst1` is at `out_pc`+4.
- `out_inst0` out INST_WIDTH: first instruction.
- `out_inst1` out INST_WIDTH: second instruction.

## Operation
- State:
  - `pc`
  - `inflight` (1 bit) and `inflight_pc`
  - 2-entry queue of {pc, inst0, inst1}, with `count` in 0..2
- Dequeue: `deq = out_valid & out_ready`.
- Issue condition: `mem_req_valid = ~RST & (redirect_valid | (count + inflight - deq < 2))`. This credit rule ensures a returning response always has a queue slot.
- Request address: `mem_req_addr = redirect_valid ? {redirect_pc[ADDR_WIDTH-1:2],2'b00} : pc`.
- On issue: `pc <= mem_req_addr + 8`, modulo 2^ADDR_WIDTH (wrap from 0xFFFFFFF8 to 0x0). `inflight <= 1` and `inflight_pc <= mem_req_addr`. Without issue: `inflight <= 0`.
- Response: if `inflight & ~redirect_valid`, enqueue {inflight_pc, mem_resp_data[31:0], mem_resp_data[63:32]}.
- Redirect, which has priority over everything except RST:
  - queue cleared (`count <= 0`)
  - the response arriving this cycle is dropped
  - the request to `redirect_pc` is issued in the same cycle
  - `out_valid` is forced to 0, so no dequeue occurs
- Output: `out_valid = (count != 0) & ~redirect_valid`. Outputs show the queue head.
- Enqueue and dequeue in the same cycle are both performed; `count` is unchanged.
- Reset: `pc <= RESET_PC`, `inflight <= 0`, `count <= 0`.
- Output values during RST: `mem_req_valid=0`, `out_valid=0`, `out_pc/out_inst0/out_inst1` = 0 (head entry cleared).
- BRAM read-disable returns 0; the unit never samples `mem_resp_data` when `inflight=0`.

## Timing
- Cycle 0 is the first cycle with RST low: request to `RESET_PC`.
- Cycle 1: response enqueued at the end of the cycle. Cycle 2: `out_valid=1`, `out_pc=RESET_PC`.
- Fetch-to-decode latency is 2 cycles. There is no bypass from `mem_resp_data` to the outputs.
- Throughput with `out_ready` held at 1: one bundle per cycle, with consecutive `out_pc` values differing by 8.
- Redirect in cycle t: new request issued in cycle t, first new bundle valid in cycle t+2. No stale bundle is visible from cycle t onward.
- Stall: `out_ready=0` for N cycles.
  - Issue stops once `count + inflight = 2`.
  - No bundle is lost or duplicated.
  - Issue resumes in the same cycle that `out_ready` returns to 1.
- RST asserted mid-stream: all state is cleared at the next edge. An in-flight response is never enqueued.

## Structure
- `fetch_pkg`:
  - `FETCH_BYTES` = 8
  - `INST_WIDTH`
  - `fetch_bundle_t` = {pc, inst0, inst1}
- Sub-module `fetch_queue`:
  - 2-entry synchronous FIFO of `fetch_bundle_t`
  - inputs: enq, deq, flush
  - outputs: count, head
- `fetch_unit` contains the PC, the in-flight tracking and the credit logic.

## Test plan
- Reset release with `out_ready=1` and the BRAM model preloaded with word i = i. Required: `out_valid` rises at cycle 2. Bundles are (0x0,0,1), (0x8,2,3), (0x10,4,5), … with one per cycle.
- Drop `out_ready` for 5 cycles mid-stream. Required:
  - `mem_req_valid` drops once `count + inflight = 2`
  - the head is held stable
  - after release the bundle sequence continues with no gaps or repeats
- Assert `redirect_valid` with `redirect_pc=0x106`. Required:
  - `mem_req_addr=0x104` in the same cycle
  - `out_valid=0` that cycle and the next
  - the next bundle is (0x104, word 0x41, word 0x42)
- Assert a redirect while the queue is full and `out_ready=0`. Required: the queue is flushed, and the first bundle after the redirect is the target's.
- Redirect to 0xFFFFFFF8 with `ADDR_WIDTH=32`. Required: bundles at 0xFFFFFFF8 then 0x00000000.
- Assert RST for 1 cycle with a request in flight. Required:
  - `out_valid=0` and `mem_req_valid=0` during reset
  - the stale response is discarded
  - the first bundle after reset is (`RESET_PC`, …)
